imem_loader: RTL and testbench

- Writer side of the read-only instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles 22-bit instructions from it.
- Writes each instruction into the instruction RAM at sequential addresses starting from 0, then checks a trailing XOR checksum.
- Holds the CPU (cpu_hold) until a load completes without error; it is the only path that fills instruction memory before run.

---
 rtl/imem_loader_pkg.sv | 30 +++
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_word_assembler.sv | 46 ++++
 rtl/imem_loader.sv | 182 ++++++++++++++++++
 tb/tb_imem_loader.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the memory modules.
package imem_loader_pkg;

  localparam int IW    = 22;
  localparam int AW    = 8;
  localparam int DEPTH = 64;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_FMT  = 2'd2;
  localparam logic [1:0] ERR_CSUM = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN,
    S_B0,
    S_B1,
    S_B2,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } ld_state_t;

  // A word count is usable only if it is non-zero and fits the RAM.
  function automatic logic len_ok(input logic [7:0] len);
    return (len != 8'd0) && (int'(len) <= DEPTH);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in and instruction RAM write port out of the loader.
// master = stream source / RAM side, slave = the loader itself.
interface imem_loader_if
  import imem_loader_pkg::*;
;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [IW-1:0] wr_data;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/imem_word_assembler.sv
// Builds a 22-bit instruction from three little-endian bytes and keeps the
// running XOR of the length byte and every data byte.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          clr,
  input  logic          ld_len,
  input  logic          lat0,
  input  logic          lat1,
  input  logic          lat2,
  input  logic [7:0]    byte_in,
  output logic [IW-1:0] word,
  output logic [7:0]    acc,
  output logic          fmt_ok
);

  // Top two bits of the third byte have no place in the instruction.
  assign fmt_ok = (byte_in[7:6] == 2'b00);

  // Latch each byte into its field; a malformed third byte is never latched.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      word <= '0;
    end else begin
      if (lat0) word[7:0]     <= byte_in;
      if (lat1) word[15:8]    <= byte_in;
      if (lat2 && fmt_ok) word[IW-1:16] <= byte_in[IW-17:0];
    end
  end

  // Checksum accumulator: seeded with the length, then folds in data bytes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (ld_len) begin
      acc <= byte_in;
    end else if (lat0 || lat1 || (lat2 && fmt_ok)) begin
      acc <= acc ^ byte_in;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: byte stream -> sequential RAM writes, with
// length/format/checksum validation; holds the CPU until a clean load.
//
// state   | meaning
// --------+-------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_LEN   | waiting for the word-count byte
// S_B0    | waiting for instruction bits [7:0]
// S_B1    | waiting for instruction bits [15:8]
// S_B2    | waiting for instruction bits [21:16] (+ format check)
// S_WRITE | one-cycle RAM write of the assembled word
// S_CSUM  | waiting for the trailing checksum byte
// S_DONE  | load good, CPU released
// S_ERR   | load aborted, err_code valid, CPU held
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  imem_loader_if.slave bus,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       cpu_hold
);

  localparam int CW = $clog2(DEPTH + 1);

  ld_state_t     state_q, state_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [AW-1:0] addr_q;
  logic [CW-1:0] words_left_q;
  logic          wr_en_q, wr_en_d;
  logic          byte_ready, accept, last_word;
  logic          asm_clr, asm_len, lat0, lat1, lat2;
  logic          addr_clr, addr_inc, cnt_load, cnt_dec;
  logic [IW-1:0] asm_word;
  logic [7:0]    asm_acc;
  logic          fmt_ok;

  imem_word_assembler u_asm (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .clr     (asm_clr),
    .ld_len  (asm_len),
    .lat0    (lat0),
    .lat1    (lat1),
    .lat2    (lat2),
    .byte_in (bus.byte_in),
    .word    (asm_word),
    .acc     (asm_acc),
    .fmt_ok  (fmt_ok)
  );

  assign byte_ready = (state_q == S_LEN) || (state_q == S_B0) || (state_q == S_B1) ||
                      (state_q == S_B2)  || (state_q == S_CSUM);
  assign accept     = bus.byte_valid && byte_ready;
  assign last_word  = (words_left_q == CW'(1));

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    wr_en_d    = 1'b0;
    asm_clr    = 1'b0;
    asm_len    = 1'b0;
    lat0       = 1'b0;
    lat1       = 1'b0;
    lat2       = 1'b0;
    addr_clr   = 1'b0;
    addr_inc   = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN;
          err_code_d = ERR_NONE;
          asm_clr    = 1'b1;
          addr_clr   = 1'b1;
        end
      end
      S_LEN: begin
        if (accept) begin
          if (!len_ok(bus.byte_in)) begin
            state_d    = S_ERR;
            err_code_d = ERR_LEN;
          end else begin
            state_d  = S_B0;
            cnt_load = 1'b1;
            asm_len  = 1'b1;
          end
        end
      end
      S_B0: begin
        if (accept) begin
          lat0    = 1'b1;
          state_d = S_B1;
        end
      end
      S_B1: begin
        if (accept) begin
          lat1    = 1'b1;
          state_d = S_B2;
        end
      end
      S_B2: begin
        if (accept) begin
          if (!fmt_ok) begin
            state_d    = S_ERR;
            err_code_d = ERR_FMT;
          end else begin
            lat2    = 1'b1;
            wr_en_d = 1'b1;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        cnt_dec = 1'b1;
        if (last_word) begin
          state_d = S_CSUM;
        end else begin
          // The final word leaves the address parked on the last entry.
          addr_inc = 1'b1;
          state_d  = S_B0;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (bus.byte_in == asm_acc) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ERR;
            err_code_d = ERR_CSUM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, error code and write strobe registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      err_code_q <= ERR_NONE;
      wr_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      wr_en_q    <= wr_en_d;
    end
  end

  // Write address and remaining-word down-counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q       <= '0;
      words_left_q <= '0;
    end else begin
      if (addr_clr)      addr_q <= '0;
      else if (addr_inc) addr_q <= addr_q + AW'(1);
      if (cnt_load)      words_left_q <= bus.byte_in[CW-1:0];
      else if (cnt_dec)  words_left_q <= words_left_q - CW'(1);
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = addr_q;
  assign bus.wr_data    = asm_word;

  assign busy     = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign err_code = err_code_q;
  assign cpu_hold = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good loads, each error class, reset mid-load
// and a full-depth load with random valid gaps and stray start pulses.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic       CLK;
  logic       RST_N;
  logic       start;
  logic       busy, done, err, cpu_hold;
  logic [1:0] err_code;

  imem_loader_if bus ();

  imem_loader dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (start),
    .bus      (bus.slave),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .cpu_hold (cpu_hold)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] wa_q[$];
  logic [IW-1:0] wd_q[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Record every RAM write seen on the bus.
  always @(negedge CLK) begin
    if (RST_N && bus.wr_en) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    int g;
    if (gaps) begin
      g = $urandom_range(0, 3);
      repeat (g) begin
        bus.byte_valid = 1'b0;
        start = ($urandom_range(0, 2) == 0);
        @(negedge CLK);
      end
      start = 1'b0;
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    n = 0;
    while (!bus.byte_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.byte_ready) chk("ready_timeout", 32'(bus.byte_ready), 32'd1);
    @(negedge CLK);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit gaps);
    foreach (s[i]) send_byte(s[i], gaps);
  endtask

  task automatic load(input logic [7:0] s[$], input bit gaps);
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    send_stream(s, gaps);
  endtask

  task automatic check_end(input string tag, input logic exp_done, input logic [1:0] exp_code,
                           input int exp_writes);
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_err"}, 32'(err), 32'(!exp_done));
    chk({tag, "_err_code"}, 32'(err_code), 32'(exp_code));
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_n_writes"}, 32'(wa_q.size()), 32'(exp_writes));
  endtask

  logic [7:0]    s[$];
  logic [7:0]    c, b0, b1, b2;
  logic [IW-1:0] exp_w[DEPTH];

  initial begin
    RST_N          = 1'b0;
    start          = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_err", 32'({done, err, err_code}), 32'd0);

    // Two words; XOR of 02 11 22 03 44 55 2A works out to 0x09.
    s = '{8'h02, 8'h11, 8'h22, 8'h03, 8'h44, 8'h55, 8'h2A, 8'h09};
    load(s, 1'b0);
    check_end("good2", 1'b1, ERR_NONE, 2);
    if (wa_q.size() == 2) begin
      chk("good2_addr0", 32'(wa_q[0]), 32'd0);
      chk("good2_data0", 32'(wd_q[0]), 32'h032211);
      chk("good2_addr1", 32'(wa_q[1]), 32'd1);
      chk("good2_data1", 32'(wd_q[1]), 32'h2A5544);
    end

    // Same words, wrong checksum: both still written, then code 3.
    s = '{8'h02, 8'h11, 8'h22, 8'h03, 8'h44, 8'h55, 8'h2A, 8'h3E};
    load(s, 1'b0);
    check_end("badcs", 1'b0, ERR_CSUM, 2);
    if (wa_q.size() == 2) chk("badcs_data1", 32'(wd_q[1]), 32'h2A5544);

    s = '{8'h00};
    load(s, 1'b0);
    check_end("len0", 1'b0, ERR_LEN, 0);

    s = '{8'h41};
    load(s, 1'b0);
    check_end("len65", 1'b0, ERR_LEN, 0);

    s = '{8'h01, 8'h11, 8'h22, 8'h40};
    load(s, 1'b0);
    check_end("fmt", 1'b0, ERR_FMT, 0);

    // Recovery from ERR; checksum 01^AA^BB^15 = 0x05.
    s = '{8'h01, 8'hAA, 8'hBB, 8'h15, 8'h05};
    load(s, 1'b0);
    check_end("recover", 1'b1, ERR_NONE, 1);
    if (wa_q.size() == 1) begin
      chk("recover_addr", 32'(wa_q[0]), 32'd0);
      chk("recover_data", 32'(wd_q[0]), 32'h15BBAA);
    end

    // Full-depth load with random gaps and start pulses while busy.
    s = {};
    s.push_back(8'(DEPTH));
    c = 8'(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      b0 = 8'($urandom_range(0, 255));
      b1 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 63));
      s.push_back(b0);
      s.push_back(b1);
      s.push_back(b2);
      c = c ^ b0 ^ b1 ^ b2;
      exp_w[i] = {b2[5:0], b1, b0};
    end
    s.push_back(c);
    load(s, 1'b1);
    check_end("full", 1'b1, ERR_NONE, DEPTH);
    for (int i = 0; i < wa_q.size() && i < DEPTH; i++) begin
      chk($sformatf("full_addr%0d", i), 32'(wa_q[i]), 32'(i));
      chk($sformatf("full_data%0d", i), 32'(wd_q[i]), 32'(exp_w[i]));
    end

    // Reset while waiting for byte 1 of a word.
    s = '{8'h01, 8'hAA};
    load(s, 1'b0);
    chk("midb1_busy_before", 32'(busy), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("midb1_busy", 32'(busy), 32'd0);
    chk("midb1_byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("midb1_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("midb1_wr_en", 32'(bus.wr_en), 32'd0);
    chk("midb1_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("midb1_wr_data", 32'(bus.wr_data), 32'd0);
    chk("midb1_status", 32'({done, err, err_code}), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
